// File: rtl/sine_wavetable.sv
// Sine wavetable oscillator: a full-cycle sine ROM indexed by the upper phase
// bits, linearly interpolated toward the next entry by the phase fraction.
package mypackage;
  localparam int unsigned PHASE_INDEX_BITS = 16;
  localparam int unsigned PHASE_ACCUMULATOR_FRACTIONAL_BITS = 6;
  typedef logic [PHASE_INDEX_BITS-1:0] phase_index_type;
  typedef logic signed [15:0] amplitude;
endpackage

module sine_wavetable #(
  parameter int unsigned PHASE_INDEX_BITS = mypackage::PHASE_INDEX_BITS,
  parameter int unsigned FRAC_BITS        = mypackage::PHASE_ACCUMULATOR_FRACTIONAL_BITS,
  parameter int unsigned AMPLITUDE_BITS   = $bits(mypackage::amplitude)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [PHASE_INDEX_BITS-1:0]      phase,
  output logic signed [AMPLITUDE_BITS-1:0] q
);

  localparam int unsigned INDEX_BITS = PHASE_INDEX_BITS - FRAC_BITS;
  localparam int unsigned ENTRIES    = 2 ** INDEX_BITS;
  localparam int unsigned PROD_BITS  = AMPLITUDE_BITS + FRAC_BITS + 2;

  // Elaboration-time table entry, rounded half away from zero.
  function automatic logic signed [AMPLITUDE_BITS-1:0] sine_entry(input int k);
    real amax;
    real v;
    real r;
    amax = (2.0 ** (AMPLITUDE_BITS - 1)) - 1.0;
    v    = amax * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(ENTRIES));
    r    = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    return AMPLITUDE_BITS'($rtoi(r));
  endfunction

  logic signed [AMPLITUDE_BITS-1:0] rom [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_rom
    localparam logic signed [AMPLITUDE_BITS-1:0] VALUE = sine_entry(i);
    assign rom[i] = VALUE;
  end

  logic [INDEX_BITS-1:0] k;
  logic [INDEX_BITS-1:0] k1;
  logic [FRAC_BITS-1:0]  f;

  // Neighbour index wraps naturally at the top of the table.
  assign k  = phase[PHASE_INDEX_BITS-1:FRAC_BITS];
  assign f  = phase[FRAC_BITS-1:0];
  assign k1 = k + INDEX_BITS'(1);

  logic signed [AMPLITUDE_BITS-1:0] t0_s1;
  logic signed [AMPLITUDE_BITS-1:0] t1_s1;
  logic [FRAC_BITS-1:0]             f_s1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t0_s1 <= '0;
      t1_s1 <= '0;
      f_s1  <= '0;
    end else begin
      t0_s1 <= rom[k];
      t1_s1 <= rom[k1];
      f_s1  <= f;
    end
  end

  logic signed [PROD_BITS-1:0] diff;
  logic signed [PROD_BITS-1:0] prod;
  logic signed [PROD_BITS-1:0] interp;

  // Wide signed datapath; arithmetic shift floors toward minus infinity.
  assign diff   = PROD_BITS'(t1_s1) - PROD_BITS'(t0_s1);
  assign prod   = diff * $signed({{(PROD_BITS - FRAC_BITS){1'b0}}, f_s1});
  assign interp = PROD_BITS'(t0_s1) + (prod >>> FRAC_BITS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= AMPLITUDE_BITS'(interp);
    end
  end

endmodule

// File: tb/tb_sine_wavetable.sv
// Bench for sine_wavetable: real-arithmetic reference model checked every
// cycle, plus directed literal expectations at key phases and around reset.
module tb_sine_wavetable;

  localparam int N  = 1024;
  localparam int FB = 6;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [15:0]        phase = 16'd0;
  logic signed [15:0] q;

  int tests = 0;
  int fails = 0;
  int tbl [N];
  int exp_s1 = 0;
  int exp_q  = 0;

  sine_wavetable dut (
    .clock (clock),
    .reset (reset),
    .phase (phase),
    .q     (q)
  );

  always #5 clock = ~clock;

  function automatic int model_q(input logic [15:0] ph);
    int  kk;
    int  kn;
    int  ff;
    real stepv;
    kk    = int'(ph[15:6]);
    ff    = int'(ph[5:0]);
    kn    = (kk + 1) % N;
    stepv = real'((tbl[kn] - tbl[kk]) * ff) / 64.0;
    return tbl[kk] + int'($floor(stepv));
  endfunction

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference pipeline: output shows the phase sampled one edge earlier.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_s1 = 0;
      exp_q  = 0;
    end else begin
      exp_q  = exp_s1;
      exp_s1 = model_q(phase);
    end
  end

  always @(negedge clock) begin
    check("model", int'(q), exp_q);
  end

  task automatic apply(input logic [15:0] ph, input string name, input int expv);
    phase = ph;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check(name, int'(q), expv);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      real v;
      v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(N));
      tbl[i] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    end

    #1 reset = 1'b1;
    #1 check("reset_q0", int'(q), 0);

    @(negedge clock);
    reset = 1'b0;
    phase = 16'd0;
    @(posedge clock);
    @(negedge clock);
    check("phase0_e1", int'(q), 0);
    @(posedge clock);
    @(negedge clock);
    check("phase0_e2", int'(q), 0);

    apply(16'(256 * 64), "k256", 32767);
    apply(16'(512 * 64), "k512", 0);
    apply(16'(768 * 64), "k768", -32767);
    apply(16'(0 * 64 + 32), "k0_f32", 100);
    apply(16'(1023 * 64 + 32), "k1023_f32", -101);
    apply(16'(1 * 64), "k1", 201);
    apply(16'(256 * 64), "k256_again", 32767);

    // Half-step streaming over a full cycle and through the wrap.
    for (int i = 0; i < 2 * N + 4; i++) begin
      phase = 16'(i * 32);
      @(negedge clock);
    end

    phase = 16'(100 * 64);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check("reset_async_mid", int'(q), 0);
    @(negedge clock);
    reset = 1'b0;
    phase = 16'(256 * 64);
    @(posedge clock);
    @(negedge clock);
    check("release_e1", int'(q), 0);
    @(posedge clock);
    @(negedge clock);
    check("release_e2", int'(q), 32767);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sine_wavetable.md
SINE_WAVETABLE -- requirements
Module: sine_wavetable

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset; clock port named clock, reset port named reset.
REQ-002 Parameter PHASE_INDEX_BITS: default mypackage::PHASE_INDEX_BITS (16); total phase width.
REQ-003 Parameter FRAC_BITS: default mypackage::PHASE_ACCUMULATOR_FRACTIONAL_BITS (6); phase fraction width.
REQ-004 Parameter AMPLITUDE_BITS: default width of mypackage::amplitude (16); output width.
REQ-005 Port clock, input, 1 bit: rising-edge clock for all state.
REQ-006 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 Port phase, input, PHASE_INDEX_BITS bits (mypackage::phase_index_type): unsigned fixed point.
  - Upper I = PHASE_INDEX_BITS-FRAC_BITS bits: table index k.
  - Lower FRAC_BITS bits: fraction f.
REQ-008 Port q, output, AMPLITUDE_BITS bits (mypackage::amplitude): registered, signed two's-complement sample.

Function
REQ-009 Table SHALL hold N=2^I entries covering one full sine cycle.
  - T[k] = round_half_away(AMAX*sin(2*pi*k/N)), AMAX = 2^(AMPLITUDE_BITS-1)-1.
  - With defaults: N=1024, AMAX=32767.
REQ-010 Contents SHALL be constant and synthesisable (ROM or case table).
  - Quarter-wave storage with symmetry folding is permitted only if every output is bit-identical to the full table.
REQ-011 Neighbour index k1 SHALL be (k+1) mod N; k=N-1 wraps to T[0].
REQ-012 Output SHALL be computed by linear interpolation:
  - q = T[k] + ((T[k1]-T[k])*f) >>> FRAC_BITS.
  - Difference and product use signed arithmetic wide enough to never overflow (AMPLITUDE_BITS+FRAC_BITS+2 bits).
  - Shift is arithmetic (floor toward minus infinity).
  - Result always lies between T[k] and T[k1] inclusive, so no saturation is needed.
REQ-013 Pipeline SHALL have latency 2 cycles; phase sampled at edge n drives q from edge n+2.
  - Stage 1 registers T[k], T[k1] and f.
  - Stage 2 registers q.
REQ-014 A new phase SHALL be accepted every cycle (throughput 1 sample/clock); no handshake.
REQ-015 f=0 SHALL yield exactly T[k].
REQ-016 Output SHALL depend only on the phase sampled two edges earlier; no other history.

Reset
REQ-017 While reset=1, q and all pipeline registers SHALL be 0 immediately, without waiting for a clock edge.
REQ-018 After reset deasserts, q SHALL stay 0 at the first edge and show the interpolated value for the phase sampled at that first edge on the second edge.
REQ-019 Reset asserted mid-stream SHALL discard in-flight samples; none SHALL appear after release.

Verification
REQ-020 phase=0 (k=0, f=0), held -> q=0 at edge 2 and thereafter.
REQ-021 Integer-only phases (f=0):
  - k=256 -> q=32767 (0x7FFF).
  - k=512 -> q=0.
  - k=768 -> q=-32767 (0x8001).
  - Each value appears 2 edges after the phase is applied.
REQ-022 Half-step fraction:
  - k=0, f=32 -> q=100 (T[1]=201; 201*32>>>6 = 100).
  - k=1023, f=32 -> q=-101 (wrap to T[0]; -201+100).
REQ-023 Streaming: phase advances by half a table step each clock, with f alternating 0 and 32 starting at 0 -> outputs follow in order with constant latency 2 and match the REQ-012 formula for every sample across one full cycle, including the N-1 to 0 wrap.
REQ-024 Reset mid-stream:
  - Assert reset asynchronously between edges while q!=0 -> q=0 immediately.
  - Release, then apply phase k=256, f=0 -> q=0 on the first edge, 32767 on the second edge.
